locked_register_bank: RTL

Parametrised bank of NUM_REGS lockable configuration registers, the successor to the single locked register. Each register has its own sticky lock bit. A lock bit is set by a lock request or a global lock, and is cleared only by reset or by a trusted unlock. Blocked writes are reported through a violation pulse, the address that was hit, and a saturating counter, for security-monitor logging. The bank sits between the register-bus decoder and the protected configuration logic.

---
 rtl/locked_register_bank.sv | 127 ++++++++++++
 1 files changed

// File: rtl/locked_register_bank.sv
// Bank of NUM_REGS lockable configuration registers with sticky per-register locks,
// blocked-write reporting (pulse, address, saturating count) and out-of-range detection.
module locked_register_bank #(
    parameter int unsigned        DATA_W    = 16,
    parameter int unsigned        NUM_REGS  = 4,
    parameter int unsigned        ADDR_W    = 2,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0,
    parameter int unsigned        VCNT_W    = 8
) (
    input  logic                         Clk,
    input  logic                         resetn,
    input  logic [ADDR_W-1:0]            addr,
    input  logic                         write,
    input  logic [DATA_W-1:0]            Data_in,
    input  logic                         Lock,
    input  logic                         lock_all,
    input  logic                         unlock,
    input  logic                         trusted,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            Data_out,
    output logic                         rd_valid,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          lock_status,
    output logic                         viol,
    output logic [ADDR_W-1:0]            viol_addr,
    output logic [VCNT_W-1:0]            viol_cnt,
    output logic                         addr_err
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t       lock_state [NUM_REGS];
    logic [DATA_W-1:0] regs       [NUM_REGS];

    logic                in_range;
    logic [NUM_REGS-1:0] sel;
    logic [DATA_W-1:0]   rd_data;
    logic                sel_locked;
    logic                wr_ok;
    logic                wr_blocked;
    logic                any_access;

    // Address decode; the write is judged against the pre-edge lock bit
    always_comb begin
        in_range   = (32'(addr) < NUM_REGS);
        sel        = '0;
        rd_data    = '0;
        sel_locked = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (in_range && (32'(addr) == i)) begin
                sel[i]     = 1'b1;
                rd_data    = regs[i];
                sel_locked = (lock_state[i] == LOCKED);
            end
        end
        wr_ok      = write && in_range && (!sel_locked || trusted);
        wr_blocked = write && in_range && sel_locked && !trusted;
        any_access = write || rd_en || Lock || unlock;
    end

    // Register data and per-register lock FSMs; lock/lock_all outrank unlock
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i]       <= RESET_VAL;
                lock_state[i] <= UNLOCKED;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && sel[i]) begin
                    regs[i] <= Data_in;
                end
                case (lock_state[i])
                    UNLOCKED: begin
                        if (lock_all || (Lock && sel[i])) begin
                            lock_state[i] <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (!lock_all && !(Lock && sel[i]) && unlock && trusted && sel[i]) begin
                            lock_state[i] <= UNLOCKED;
                        end
                    end
                    default: lock_state[i] <= UNLOCKED;
                endcase
            end
        end
    end

    // Read data, violation reporting and address-error pulse
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            Data_out  <= '0;
            rd_valid  <= 1'b0;
            viol      <= 1'b0;
            viol_addr <= '0;
            viol_cnt  <= '0;
            addr_err  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                Data_out <= rd_data;
            end
            viol <= wr_blocked;
            if (wr_blocked) begin
                viol_addr <= addr;
                if (viol_cnt != {VCNT_W{1'b1}}) begin
                    viol_cnt <= viol_cnt + VCNT_W'(1);
                end
            end
            addr_err <= any_access && !in_range;
        end
    end

    always_comb begin
        regs_flat   = '0;
        lock_status = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs[i];
            lock_status[i]                = (lock_state[i] == LOCKED);
        end
    end

endmodule
